spi_tx_sched: RTL

SPI_TX_SCHED -- requirements
Module: spi_tx_sched

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi.sv | 61 ++++++
 rtl/spi_fifo.sv | 59 +++++
 rtl/spi_tx_sched.sv | 119 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and the transmit scheduler state encoding.
package spi_pkg;

    localparam int unsigned SPI_WIDTH   = 13;
    localparam int unsigned SPI_CLKFREQ = 2000;
    localparam int unsigned SPI_SPIFREQ = 100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_GAP
    } sched_state_e;

endpackage

// File: rtl/spi.sv
// Minimal SPI master: MSB-first shift of one WIDTH-bit frame per load strobe,
// DIV system clocks per bit, sclk high in the second half of each bit.
module spi
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = SPI_WIDTH,
    parameter int unsigned CLKFREQ = SPI_CLKFREQ,
    parameter int unsigned SPIFREQ = SPI_SPIFREQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] mtx_dat,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n
);

    localparam int unsigned DIV = CLKFREQ / SPIFREQ;
    localparam int unsigned DW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    dcnt;
    logic [BW-1:0]    bcnt;
    logic             active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            dcnt   <= '0;
            bcnt   <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= mtx_dat;
            dcnt   <= '0;
            bcnt   <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (dcnt == DIV_LAST) begin
                dcnt  <= '0;
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                if (bcnt == BIT_LAST) begin
                    active <= 1'b0;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    assign sclk = active && (dcnt >= DIV_HALF);
    assign mosi = shreg[WIDTH-1];
    assign cs_n = !active;

endmodule

// File: rtl/spi_fifo.sv
// Word queue for the SPI scheduler; pointers carry one extra wrap bit so
// full and empty are distinguishable, flags and level are registered.
module spi_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_n, rd_ptr_n;
    logic             push, pop;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            empty  <= (wr_ptr_n == rd_ptr_n);
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            level  <= wr_ptr_n - rd_ptr_n;
        end
    end

endmodule

// File: rtl/spi_tx_sched.sv
// Queues words and feeds them to spi one frame at a time with an idle gap.
// Optional SPI_TX_SCHED_OVF_CNT_EN adds an 8-bit saturating dropped-write count.
module spi_tx_sched
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = SPI_WIDTH,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CLKFREQ = SPI_CLKFREQ,
    parameter int unsigned SPIFREQ = SPI_SPIFREQ,
    parameter int unsigned GAP     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [WIDTH-1:0]       mtx_dat,
    output logic                   load,
    output logic                   busy
`ifdef SPI_TX_SCHED_OVF_CNT_EN
    ,
    output logic [7:0]             ovf_cnt
`endif
);

    localparam int unsigned DIV     = CLKFREQ / SPIFREQ;
    localparam int unsigned FRAME   = WIDTH * DIV;
    localparam int unsigned GAP_CYC = GAP * DIV;
    localparam int unsigned CNT_MAX = (FRAME > GAP_CYC) ? FRAME : GAP_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam bit HAS_GAP = (GAP != 0);

    sched_state_e     state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             pop;
    logic [WIDTH-1:0] head_dat;

    spi_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_dat (wr_dat),
        .rd_en  (pop),
        .rd_dat (head_dat),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mtx_dat <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) begin
                mtx_dat <= head_dat;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_n   = '0;
                state_n = S_XFER;
            end
            S_XFER: begin
                if (cnt == FRAME_LAST) begin
                    cnt_n   = '0;
                    state_n = HAS_GAP ? S_GAP : S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign load = (state == S_LOAD);
    assign busy = (state != S_IDLE);

`ifdef SPI_TX_SCHED_OVF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (wr_en && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule
